// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int DEF_LATENCY = 2;
    localparam int DEF_DEPTH   = 64;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request snapshot taken at acceptance; held until the response cycle.
    typedef struct packed {
        logic              wr;
        logic              rd;
        logic              byte_acc;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/byte_lane_mux.sv
// Byte-lane steering: zero-extended lane extraction for loads, lane merge for stores.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module byte_lane_mux
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] mem_word,
    input  logic [1:0]        lane,
    input  logic              byte_acc,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rd_word,
    output logic [WORD_W-1:0] wr_word
);

    logic [BYTE_W-1:0] rd_byte;

    // Load path: pick the little-endian lane and zero-extend on byte accesses.
    always_comb begin
        rd_byte = mem_word[{lane, 3'b000} +: BYTE_W];
        rd_word = byte_acc ? {{(WORD_W-BYTE_W){1'b0}}, rd_byte} : mem_word;
    end

    // Store path: byte stores replace only the addressed lane of the current word.
    always_comb begin
        wr_word = wdata;
        if (byte_acc) begin
            wr_word = mem_word;
            wr_word[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store against a local word array.
// Latency: StallM high LATENCY+1 cycles from acceptance, response in the following cycle.
// Backpressure: StallM holds the requester; a request still present in RESP is not re-accepted.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic              BEDmemM,
    input  logic [WORD_W-1:0] AddrM,
    input  logic [WORD_W-1:0] WriteDataM,
    output logic [WORD_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              ValidM,
    output logic              ErrM
);

    localparam int IW = $clog2(DEPTH);
    localparam int AW = IW + 2;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              stall;
    logic              commit;
    logic              load;
    logic [IW-1:0]     idx;
    logic              oor;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] wr_word;

    // Any address bit above the word index makes the access out of range; the
    // second term only matters for non-power-of-two depths.
    assign idx = req_q.addr[AW-1:2];
    assign oor = ((req_q.addr >> AW) != '0) || ({1'b0, idx} >= (IW+1)'(DEPTH));

    byte_lane_mux u_lane (
        .mem_word (mem[idx]),
        .lane     (req_q.addr[1:0]),
        .byte_acc (req_q.byte_acc),
        .wdata    (req_q.wdata),
        .rd_word  (rd_word),
        .wr_word  (wr_word)
    );

    // Next-state, counter and stall decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWriteM || MemReadM) begin
                    accept  = 1'b1;
                    stall   = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                // <= rather than == so a zero count can never strand the FSM.
                if (cnt_q <= 4'd1) begin
                    enter_resp = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writes win when both request lines are high; reads see pre-commit contents.
    assign commit = enter_resp && req_q.wr && !oor;
    assign load   = enter_resp && req_q.rd && !req_q.wr;

    // State, counter and request capture; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= '{wr:       MemWriteM,
                           rd:       MemReadM,
                           byte_acc: BEDmemM,
                           addr:     AddrM,
                           wdata:    WriteDataM};
            end
        end
    end

    // Load data register: updated only on the edge entering RESP, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (load) begin
            rdata_q <= oor ? '0 : rd_word;
        end
    end

    // Backing storage: no reset, contents survive reset assertion.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx] <= wr_word;
        end
    end

    // Stall is gated by reset so it drops asynchronously with the rest.
    assign StallM    = reset && stall;
    assign ValidM    = (state_q == RESP) && req_q.rd && !req_q.wr;
    assign ErrM      = (state_q == RESP) && oor;
    assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function, LATENCY=1 for streaming.
// Latency: n/a.
// Backpressure: requests are held until StallM drops, as a pipeline would.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        wr, rd, be;
    logic [31:0] addr, wdata, rdata;
    logic        stall, valid, err;

    logic        wr1, rd1, be1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        stall1, valid1, err1;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.LATENCY(2), .DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (wr),
        .MemReadM   (rd),
        .BEDmemM    (be),
        .AddrM      (addr),
        .WriteDataM (wdata),
        .ReadDataM  (rdata),
        .StallM     (stall),
        .ValidM     (valid),
        .ErrM       (err)
    );

    dmem_responder #(.LATENCY(1), .DEPTH(64)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (wr1),
        .MemReadM   (rd1),
        .BEDmemM    (be1),
        .AddrM      (addr1),
        .WriteDataM (wdata1),
        .ReadDataM  (rdata1),
        .StallM     (stall1),
        .ValidM     (valid1),
        .ErrM       (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 instance, hold it while stalled, then
    // check the stall length and the response-cycle outputs.
    task automatic access(input logic w, input logic r, input logic b,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_v, input logic exp_e,
                          input logic [31:0] exp_d, input string tag);
        int  n    = 0;
        bit  done = 0;
        wr = w; rd = r; be = b; addr = a; wdata = d;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (stall) begin
                n++;
                chk({tag, " valid_in_stall"}, {31'd0, valid}, 32'd0);
                @(posedge clk); #1;
            end else begin
                done = 1;
            end
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'd3);
        chk({tag, " valid"}, {31'd0, valid}, {31'd0, exp_v});
        chk({tag, " err"},   {31'd0, err},   {31'd0, exp_e});
        chk({tag, " rdata"}, rdata, exp_d);
        wr = 1'b0; rd = 1'b0; be = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        wr = 0; rd = 0; be = 0; addr = 0; wdata = 0;
        wr1 = 0; rd1 = 0; be1 = 0; addr1 = 0; wdata1 = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        rd = 1'b1;
        @(negedge clk);
        chk("reset stall (request held)", {31'd0, stall}, 32'd0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset err",   {31'd0, err},   32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset stall1", {31'd0, stall1}, 32'd0);
        @(posedge clk); #1;
        rd = 1'b0;
        reset = 1'b1;

        // Word write then read; first request right after reset release.
        access(1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, "wr_word_10");
        access(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF, "rd_word_10");

        // Byte lanes; upper store-data bits must be ignored on a byte store.
        access(1, 0, 0, 32'h20, 32'h11223344, 0, 0, 32'hDEADBEEF, "wr_word_20");
        access(1, 0, 1, 32'h22, 32'hFFFFFFAA, 0, 0, 32'hDEADBEEF, "wr_byte_22");
        access(0, 1, 0, 32'h20, 32'h0, 1, 0, 32'h11AA3344, "rd_word_20");
        access(0, 1, 1, 32'h23, 32'h0, 1, 0, 32'h00000011, "rd_byte_23");
        access(0, 1, 1, 32'h20, 32'h0, 1, 0, 32'h00000044, "rd_byte_20");

        // Out of range: 0x400 aliases word 0 if the upper bits were ignored.
        access(1, 0, 0, 32'h0,   32'h0BADF00D, 0, 0, 32'h00000044, "wr_word_0");
        access(1, 0, 0, 32'h400, 32'h5,        0, 1, 32'h00000044, "wr_oor");
        access(0, 1, 0, 32'h400, 32'h0,        1, 1, 32'h0,        "rd_oor");
        access(0, 1, 0, 32'h0,   32'h0,        1, 0, 32'h0BADF00D, "rd_word_0");

        // Both request lines high behaves as a write.
        access(1, 1, 0, 32'h8, 32'h12345678, 0, 0, 32'h0BADF00D, "wr_rd_both_8");
        access(0, 1, 0, 32'h8, 32'h0,        1, 0, 32'h12345678, "rd_word_8");

        // Reset during WAIT aborts the store.
        access(1, 0, 0, 32'h4, 32'h1, 0, 0, 32'h12345678, "wr_word_4");
        wr = 1'b1; addr = 32'h4; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("abort accept stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("abort stall", {31'd0, stall}, 32'd0);
        chk("abort valid", {31'd0, valid}, 32'd0);
        chk("abort err",   {31'd0, err},   32'd0);
        chk("abort rdata", rdata, 32'd0);
        wr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        access(0, 1, 0, 32'h4,  32'h0, 1, 0, 32'h00000001, "rd_after_abort_4");
        access(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF, "rd_retained_10");

        // LATENCY=1: preload a word, then hold a read continuously.
        wr1 = 1'b1; addr1 = 32'h3C; wdata1 = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lat1 wr stall c%0d", i), {31'd0, stall1}, (i == 2) ? 32'd0 : 32'd1);
            chk($sformatf("lat1 wr valid c%0d", i), {31'd0, valid1}, 32'd0);
            if (i == 2) wr1 = 1'b0;
            @(posedge clk); #1;
        end
        rd1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("lat1 rd stall c%0d", i), {31'd0, stall1}, (i % 3 == 2) ? 32'd0 : 32'd1);
            chk($sformatf("lat1 rd valid c%0d", i), {31'd0, valid1}, (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2) chk($sformatf("lat1 rd data c%0d", i), rdata1, 32'hCAFEF00D);
            @(posedge clk); #1;
        end
        rd1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
